// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
//
// Sequenced ALU control unit. Decodes alu_op / function_input into a
// registered 3-bit alu_control code. Single-cycle operations finish on the
// accept edge. MUL and DIV start a multi-cycle unit and hold the block busy
// for a programmable number of cycles. Illegal encodings produce a NOP code
// and are counted. A flush aborts an in-flight multi-cycle operation.
//
// Handshake: a request is taken on a rising edge where
// valid_in && ready_out && !flush. ready_out is high only in IDLE. Upstream
// keeps valid_in and the request fields stable until that edge. valid_in is
// ignored in RUN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_in            request valid
//   ready_out           block can accept (state == IDLE)
//   alu_op[1:0]         operation class
//   function_input      function field (FUNCT_W bits)
//   flush               synchronous abort / accept blocker
//   alu_control[2:0]    registered control code, held between operations
//   valid_out           one-cycle pulse when the control code is final
//   illegal             one-cycle pulse with valid_out for illegal encodings
//   mc_start            one-cycle pulse starting the multi-cycle unit
//   mc_abort            one-cycle pulse when RUN is flushed
//   busy                high while in RUN
//   illegal_count[7:0]  saturating count of accepted illegal requests
// ---------------------------------------------------------------------------
module alu_control_seq #(
  parameter int FUNCT_W    = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] function_input,
  input  logic               flush,
  output logic [2:0]         alu_control,
  output logic               valid_out,
  output logic               illegal,
  output logic               mc_start,
  output logic               mc_abort,
  output logic               busy,
  output logic [7:0]         illegal_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] CODE_AND = 3'b000;
  localparam logic [2:0] CODE_OR  = 3'b001;
  localparam logic [2:0] CODE_ADD = 3'b010;
  localparam logic [2:0] CODE_MUL = 3'b011;
  localparam logic [2:0] CODE_DIV = 3'b100;
  localparam logic [2:0] CODE_NOP = 3'b101;
  localparam logic [2:0] CODE_SUB = 3'b110;
  localparam logic [2:0] CODE_SLT = 3'b111;

  // The counter is loaded with N-1 so that cnt == 0 is seen on edge N.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       alu_control_q, alu_control_d;
  logic             valid_out_q, valid_out_d;
  logic             illegal_q, illegal_d;
  logic             mc_start_q, mc_start_d;
  logic             mc_abort_q, mc_abort_d;
  logic [7:0]       illegal_count_q, illegal_count_d;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic             upper_nz;
  logic [2:0]       dec_code;
  logic             dec_illegal;
  logic             dec_mc;
  logic [CNT_W-1:0] dec_load;

  // Function bits above [2:0] only exist when FUNCT_W > 3; any of them set
  // makes an R-type request illegal.
  generate
    if (FUNCT_W > 3) begin : g_upper
      assign upper_nz = |function_input[FUNCT_W-1:3];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  always_comb begin
    dec_code    = CODE_NOP;
    dec_illegal = 1'b1;
    dec_mc      = 1'b0;
    dec_load    = '0;
    case (alu_op)
      2'b00: begin
        dec_code    = CODE_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_code    = CODE_SUB;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        if (!upper_nz) begin
          dec_illegal = 1'b0;
          case (function_input[2:0])
            3'b000:  dec_code = CODE_ADD;
            3'b001:  dec_code = CODE_SUB;
            3'b010:  dec_code = CODE_AND;
            3'b011:  dec_code = CODE_OR;
            3'b100:  dec_code = CODE_SLT;
            3'b101: begin
              dec_code = CODE_MUL;
              dec_mc   = 1'b1;
              dec_load = MUL_LOAD;
            end
            3'b110: begin
              dec_code = CODE_DIV;
              dec_mc   = 1'b1;
              dec_load = DIV_LOAD;
            end
            default: begin
              dec_code    = CODE_NOP;
              dec_illegal = 1'b1;
            end
          endcase
        end
      end
      default: begin
        dec_code    = CODE_NOP;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  logic accept;
  assign accept = valid_in && (state_q == ST_IDLE) && !flush;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    alu_control_d   = alu_control_q;
    valid_out_d     = 1'b0;
    illegal_d       = 1'b0;
    mc_start_d      = 1'b0;
    mc_abort_d      = 1'b0;
    illegal_count_d = illegal_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_control_d = dec_code;
          if (dec_mc) begin
            mc_start_d = 1'b1;
            cnt_d      = dec_load;
            state_d    = ST_RUN;
          end else begin
            valid_out_d = 1'b1;
            illegal_d   = dec_illegal;
            if (dec_illegal && (illegal_count_q != 8'hFF)) begin
              illegal_count_d = illegal_count_q + 8'd1;
            end
          end
        end
      end
      ST_RUN: begin
        // Flush wins over completion; the code of the aborted op is kept.
        if (flush) begin
          state_d    = ST_IDLE;
          mc_abort_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          valid_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      alu_control_q   <= 3'b000;
      valid_out_q     <= 1'b0;
      illegal_q       <= 1'b0;
      mc_start_q      <= 1'b0;
      mc_abort_q      <= 1'b0;
      illegal_count_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      alu_control_q   <= alu_control_d;
      valid_out_q     <= valid_out_d;
      illegal_q       <= illegal_d;
      mc_start_q      <= mc_start_d;
      mc_abort_q      <= mc_abort_d;
      illegal_count_q <= illegal_count_d;
    end
  end

  assign ready_out     = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_RUN);
  assign alu_control   = alu_control_q;
  assign valid_out     = valid_out_q;
  assign illegal       = illegal_q;
  assign mc_start      = mc_start_q;
  assign mc_abort      = mc_abort_q;
  assign illegal_count = illegal_count_q;

endmodule
